// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot loader and the CPU that it releases from reset.
// - State encoding of the loader FSM.
// - Load start address (also the CPU reset PC) and the largest legal word count.
// - Helper that identifies the states in which the loader takes bytes.
package prog_loader_pkg;

    typedef logic [3:0] state_t;

    // First program word address and CPU reset PC; MAX_WORDS fills memory up to 16'hFFFF.
    localparam logic [15:0] LOADER_PROG_START = 16'h00FF;
    localparam logic [15:0] LOADER_MAX_WORDS  = 16'hFF01;

    localparam logic [3:0] ST_CNT_HI = 4'd0;
    localparam logic [3:0] ST_CNT_LO = 4'd1;
    localparam logic [3:0] ST_DAT_HI = 4'd2;
    localparam logic [3:0] ST_DAT_LO = 4'd3;
    localparam logic [3:0] ST_WRITE  = 4'd4;
    localparam logic [3:0] ST_CHK_HI = 4'd5;
    localparam logic [3:0] ST_CHK_LO = 4'd6;
    localparam logic [3:0] ST_DONE   = 4'd7;
    localparam logic [3:0] ST_ERROR  = 4'd8;

    // True in the count, data and checksum byte states.
    function automatic logic is_byte_state(input state_t s);
        return (s == ST_CNT_HI) || (s == ST_CNT_LO) ||
               (s == ST_DAT_HI) || (s == ST_DAT_LO) ||
               (s == ST_CHK_HI) || (s == ST_CHK_LO);
    endfunction

endpackage

// File: rtl/prog_loader_byte_pair.sv
// byte_pair: joins two accepted bytes (high byte first) into one 16-bit word.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (drops a held high byte)
//   byte_data   - byte presented by the host link
//   accept      - byte_data is taken this cycle
//   word        - {held high byte, byte_data}; meaningful when word_ready is 1
//   word_ready  - one-cycle pulse on the cycle the low byte is accepted
module byte_pair
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_data,
    input  logic        accept,
    output logic [15:0] word,
    output logic        word_ready
);

    logic       lo_phase;
    logic [7:0] hi_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_phase <= 1'b0;
        end else if (accept) begin
            lo_phase <= ~lo_phase;
        end
    end

    // The high byte needs no reset: clearing lo_phase already discards it.
    always_ff @(posedge clk) begin
        if (accept && !lo_phase) begin
            hi_byte <= byte_data;
        end
    end

    // The word is formed combinationally so the FSM can act on it in the same
    // cycle that the low byte arrives.
    assign word       = {hi_byte, byte_data};
    assign word_ready = accept && lo_phase;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a program image over a byte link, writes it into RAM from
// PROG_START upward and releases the CPU from reset once the checksum matches.
// Stream: count word, count data words, checksum word; each word high byte first.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_data       - byte from the host link
//   in_valid      - in_data holds a byte
//   in_ready      - the loader takes the byte this cycle
//   mem_addr      - RAM write address (held between writes)
//   mem_wdata     - RAM write data (held between writes)
//   mem_we        - one-cycle RAM write strobe
//   cpu_rst       - CPU reset, released only after a good load
//   load_done     - image loaded and checksum matched
//   load_err      - load aborted (bad count or checksum mismatch)
//   words_loaded  - number of data words written so far
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [15:0] PROG_START = LOADER_PROG_START,
    parameter logic [15:0] MAX_WORDS  = LOADER_MAX_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    state_t      state;
    state_t      state_next;
    logic [15:0] count;
    logic [15:0] sum;
    logic        accept;
    logic [15:0] word;
    logic        word_ready;

    // Outputs are gated with rst so they read 0 from the first reset cycle,
    // before the state register has been forced.
    assign in_ready  = !rst && is_byte_state(state);
    assign accept    = in_valid && in_ready;
    assign mem_we    = !rst && (state == ST_WRITE);
    assign load_done = !rst && (state == ST_DONE);
    assign load_err  = !rst && (state == ST_ERROR);
    assign cpu_rst   = rst || (state != ST_DONE);

    byte_pair u_byte_pair (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (in_data),
        .accept     (accept),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_CNT_HI: if (accept) state_next = ST_CNT_LO;
            ST_CNT_LO: begin
                if (word_ready) begin
                    if (word > MAX_WORDS)  state_next = ST_ERROR;
                    else if (word == 16'd0) state_next = ST_CHK_HI;
                    else                    state_next = ST_DAT_HI;
                end
            end
            ST_DAT_HI: if (accept) state_next = ST_DAT_LO;
            ST_DAT_LO: if (word_ready) state_next = ST_WRITE;
            // words_loaded is incremented on this same edge, hence the +1.
            ST_WRITE:  state_next = (words_loaded + 16'd1 == count) ? ST_CHK_HI : ST_DAT_HI;
            ST_CHK_HI: if (accept) state_next = ST_CHK_LO;
            ST_CHK_LO: begin
                if (word_ready) state_next = (word == sum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE:   state_next = ST_DONE;
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_CNT_HI;
            count        <= 16'd0;
            sum          <= 16'd0;
            words_loaded <= 16'd0;
            mem_addr     <= 16'd0;
            mem_wdata    <= 16'd0;
        end else begin
            state <= state_next;
            if ((state == ST_CNT_LO) && word_ready) begin
                count <= word;
            end
            // Address and data are staged when the word completes so they are
            // stable through WRITE and held afterwards.
            if ((state == ST_DAT_LO) && word_ready) begin
                sum       <= sum + word;
                mem_addr  <= PROG_START + words_loaded;
                mem_wdata <= word;
            end
            if (state == ST_WRITE) begin
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter PROG_START, default 16'h00FF: the memory address where the first program word is written, and the CPU's reset PC.
REQ-002 Parameter MAX_WORDS, default 16'hFF01: the largest legal word count, so that PROG_START+MAX_WORDS-1 = 16'hFFFF.
REQ-003 Port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_data, input, 8: serial byte from the host link.
REQ-006 Port in_valid, input, 1: in_data holds a byte.
REQ-007 Port in_ready, output, 1: the loader accepts the byte this cycle.
REQ-008 Port mem_addr, output, 16: write address to ram.
REQ-009 Port mem_wdata, output, 16: write data to ram.
REQ-010 Port mem_we, output, 1: one-cycle write strobe to ram.
REQ-011 Port cpu_rst, output, 1: drives the CPU rst; high holds risc16 in reset.
REQ-012 Port load_done, output, 1: the image was loaded and the checksum matched.
REQ-013 Port load_err, output, 1: the load was aborted because of a bad count or a checksum mismatch.
REQ-014 Port words_loaded, output, 16: number of data words written so far.

Function
REQ-015 A byte SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 The stream format SHALL be: count word, then count data words, then checksum word; every word is sent high byte first.
REQ-017 The FSM SHALL have the states CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO, DONE and ERROR.
REQ-018 The FSM SHALL wait in each *_HI and *_LO state until a byte is accepted, then advance.
REQ-019 in_ready SHALL be 1 only in CNT_*, DAT_* and CHK_* states.
REQ-020 On leaving CNT_LO the FSM SHALL go to ERROR if the count > MAX_WORDS, to CHK_HI if the count = 0, and to DAT_HI otherwise.
REQ-021 On leaving DAT_LO the FSM SHALL go to WRITE; WRITE lasts exactly one cycle.
REQ-022 In WRITE, mem_we SHALL be 1, mem_addr SHALL be PROG_START + words_loaded (mod 2^16), and mem_wdata SHALL be the assembled word.
REQ-023 words_loaded SHALL increment at the end of WRITE.
REQ-024 After WRITE the FSM SHALL go to CHK_HI if words_loaded = count, else to DAT_HI.
REQ-025 The running checksum SHALL be the 16-bit wrap-around sum of all data words, with carries discarded.
REQ-026 On leaving CHK_LO the FSM SHALL go to DONE if the received checksum equals the running sum, else to ERROR.
REQ-027 DONE and ERROR SHALL be terminal; only rst leaves them, and bytes offered there are never accepted.
REQ-028 cpu_rst SHALL be 1 in every state except DONE, where it is 0 from the first DONE cycle onward.
REQ-029 load_done SHALL be 1 only in DONE.
REQ-030 load_err SHALL be 1 only in ERROR.
REQ-031 mem_we SHALL be 0 outside WRITE.
REQ-032 mem_addr and mem_wdata SHALL hold their last values when mem_we is 0.
REQ-033 Maximum throughput SHALL be one word per 3 cycles (2 bytes + WRITE).

Reset
REQ-034 While rst is 1 the FSM SHALL be forced to CNT_HI.
REQ-035 While rst is 1 the following SHALL be 0: in_ready, mem_we, load_done, load_err, words_loaded, the running sum, mem_addr and mem_wdata.
REQ-036 cpu_rst SHALL be 1 during rst.
REQ-037 An rst assertion mid-load SHALL discard any partial byte or word, and SHALL leave words already written in ram unchanged.
REQ-038 in_ready SHALL become 1 on the first cycle after rst deasserts.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding, PROG_START and MAX_WORDS, so that risc16 and prog_loader agree on the start address.
REQ-040 One sub-module, byte_pair, SHALL assemble two accepted bytes into a 16-bit word with a word-ready pulse; all other logic stays in prog_loader.

Verification
REQ-041 Scenario count = 3, data 1234/ABCD/0001, checksum BE02: writes 00FF=1234, 0100=ABCD, 0101=0001; then load_done=1 and cpu_rst=0.
REQ-042 Same stream with checksum BE03: three writes occur, then load_err=1, cpu_rst stays 1, and in_ready=0.
REQ-043 Scenario count = 0, checksum 0000: no mem_we; load_done=1 after 4 accepted bytes.
REQ-044 Scenario count = FF02: ERROR immediately after byte 2, with no writes.
REQ-045 Scenario with in_valid toggling randomly 50% over a 5-word image: the writes and the checksum are identical to the gap-free run, with no byte lost or duplicated.
REQ-046 Scenario with rst pulsed after 5 bytes of a 3-word load, then a full valid stream: the load restarts at address 00FF and ends with load_done=1.
